// File: rtl/ysyx_22050854_pkg.sv
// Shared FSM encoding and fetch constants for the ysyx_22050854 front end.
package ysyx_22050854_pkg;

   localparam int unsigned INST_W       = 32;
   localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      FULL = 2'd3
   } ifu_state_t;

endpackage

// File: rtl/ysyx_22050854_ifu_skid.sv
// One-entry holding buffer for a fetch response that arrives while IF/ID is stalled.
module ysyx_22050854_ifu_skid
   import ysyx_22050854_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              wr_en,
   input  logic [31:0]       wr_pc,
   input  logic [INST_W-1:0] wr_inst,
   output logic              valid,
   output logic [31:0]       pc,
   output logic [INST_W-1:0] inst
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         pc    <= '0;
         inst  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (wr_en) begin
         valid <= 1'b1;
         pc    <= wr_pc;
         inst  <= wr_inst;
      end
   end

endmodule

// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding the IF/ID register.
// Define YSYX_22050854_IFU_PERF_EN to add the fetch/flush performance counters.
module ysyx_22050854_ifu
   import ysyx_22050854_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              jump,
   input  logic [31:0]       next_pc,
   input  logic              stall,
   output logic              inst_req,
   output logic [31:0]       inst_addr,
   input  logic              inst_ready,
   input  logic              inst_rvalid,
   input  logic [INST_W-1:0] inst_rdata,
   output logic              IDreg_valid,
   output logic [31:0]       IDreg_pc,
   output logic [INST_W-1:0] IDreg_inst
`ifdef YSYX_22050854_IFU_PERF_EN
   ,
   output logic [63:0]       perf_fetch_cnt,
   output logic [63:0]       perf_flush_cnt
`endif
);

   ifu_state_t        state;
   logic [31:0]       fetch_pc;
   logic              drop;
   logic              skid_valid;
   logic [31:0]       skid_pc;
   logic [INST_W-1:0] skid_inst;
   logic              rsp_keep;
   logic              can_load;
   logic              load_rsp;
   logic              load_skid;
   logic              to_skid;

   // A response is kept only when it belongs to the current path and no redirect wins this cycle.
   assign rsp_keep  = (state == WAIT) && inst_rvalid && !drop && !jump;
   assign can_load  = !IDreg_valid || !stall;
   assign load_rsp  = rsp_keep && can_load;
   assign to_skid   = rsp_keep && !can_load;
   assign load_skid = (state == FULL) && !stall && !jump && skid_valid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         inst_addr <= RESET_PC;
         inst_req  <= 1'b0;
         drop      <= 1'b0;
      end else if (jump) begin
         fetch_pc <= next_pc;
         case (state)
            REQ: begin
               // inst_addr stays put: the memory may still be looking at the old request.
               drop <= 1'b1;
               if (inst_ready) begin
                  state    <= WAIT;
                  inst_req <= 1'b0;
               end
            end
            WAIT: begin
               if (inst_rvalid) begin
                  state     <= REQ;
                  inst_req  <= 1'b1;
                  inst_addr <= next_pc;
                  drop      <= 1'b0;
               end else begin
                  drop <= 1'b1;
               end
            end
            default: begin
               state     <= REQ;
               inst_req  <= 1'b1;
               inst_addr <= next_pc;
               drop      <= 1'b0;
            end
         endcase
      end else begin
         case (state)
            IDLE: begin
               state     <= REQ;
               inst_req  <= 1'b1;
               inst_addr <= fetch_pc;
            end
            REQ: begin
               if (inst_ready) begin
                  state    <= WAIT;
                  inst_req <= 1'b0;
               end
            end
            WAIT: begin
               if (inst_rvalid) begin
                  if (drop) begin
                     drop      <= 1'b0;
                     state     <= REQ;
                     inst_req  <= 1'b1;
                     inst_addr <= fetch_pc;
                  end else begin
                     fetch_pc <= fetch_pc + 32'd4;
                     if (can_load) begin
                        state     <= REQ;
                        inst_req  <= 1'b1;
                        inst_addr <= fetch_pc + 32'd4;
                     end else begin
                        state <= FULL;
                     end
                  end
               end
            end
            FULL: begin
               if (!stall) begin
                  state     <= REQ;
                  inst_req  <= 1'b1;
                  inst_addr <= fetch_pc;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         IDreg_valid <= 1'b0;
         IDreg_pc    <= '0;
         IDreg_inst  <= '0;
      end else if (jump) begin
         IDreg_valid <= 1'b0;
      end else if (load_rsp) begin
         IDreg_valid <= 1'b1;
         IDreg_pc    <= inst_addr;
         IDreg_inst  <= inst_rdata;
      end else if (load_skid) begin
         IDreg_valid <= 1'b1;
         IDreg_pc    <= skid_pc;
         IDreg_inst  <= skid_inst;
      end else if (IDreg_valid && !stall) begin
         IDreg_valid <= 1'b0;
      end
   end

   ysyx_22050854_ifu_skid u_skid (
      .clock   (clock),
      .reset   (reset),
      .clear   (jump || load_skid),
      .wr_en   (to_skid),
      .wr_pc   (inst_addr),
      .wr_inst (inst_rdata),
      .valid   (skid_valid),
      .pc      (skid_pc),
      .inst    (skid_inst)
   );

`ifdef YSYX_22050854_IFU_PERF_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         perf_fetch_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (load_rsp || load_skid) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
         if (jump) perf_flush_cnt <= perf_flush_cnt + 64'd1;
      end
   end
`endif

endmodule

// File: doc/ysyx_22050854_ifu.md
YSYX_22050854_IFU -- requirements
Module: ysyx_22050854_ifu

Interface
REQ-001 Parameter: RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 clock  input  1  sole clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 jump  input  1  redirect from the PC stage; flushes the wrong path.
REQ-005 next_pc  input  32  redirect target; sampled only when jump=1.
REQ-006 stall  input  1  ID stage cannot accept (data conflict or suspend).
REQ-007 inst_req  output  1  fetch request to instruction memory.
REQ-008 inst_addr  output  32  fetch address; stable while inst_req=1 and inst_ready=0.
REQ-009 inst_ready  input  1  memory accepts the request this cycle.
REQ-010 inst_rvalid  input  1  single-cycle response strobe.
REQ-011 inst_rdata  input  32  instruction word, valid with inst_rvalid.
REQ-012 IDreg_valid  output  1  IF/ID register holds a live instruction.
REQ-013 IDreg_pc  output  32  PC of the IF/ID instruction.
REQ-014 IDreg_inst  output  32  IF/ID instruction word.

Function
REQ-015 The block SHALL allow at most one outstanding request; the FSM states are IDLE, REQ, WAIT and FULL.
REQ-016 IDLE SHALL go to REQ on the first clock after reset is released.
REQ-017 REQ SHALL drive inst_req=1 and inst_addr=fetch_pc, and SHALL go to WAIT on inst_ready=1.
REQ-018 In WAIT, on inst_rvalid with no drop pending, the response SHALL:
- load IF/ID when IDreg_valid=0 or stall=0, then go to REQ with fetch_pc+4;
- otherwise be written to the skid register, then go to FULL.
REQ-019 FULL SHALL hold inst_req=0, and SHALL move the skid contents into IF/ID and go to REQ on the first cycle with stall=0.
REQ-020 A consume SHALL occur when IDreg_valid=1 and stall=0; without a new load, IDreg_valid SHALL clear the next cycle.
REQ-021 Back-to-back operation SHALL be supported: consume and load in the same cycle replace the IF/ID contents.
REQ-022 On jump=1 the block SHALL, next edge:
- clear IDreg_valid and the skid register;
- set fetch_pc to next_pc;
- set a drop flag if a request is in flight (WAIT) or is being accepted this cycle (REQ with inst_ready=1).
REQ-023 On jump=1 in REQ with inst_ready=0, inst_addr SHALL stay unchanged, the request SHALL continue, and its response SHALL be dropped.
REQ-024 A response received with the drop flag set SHALL be discarded, SHALL clear the flag, and SHALL move the FSM to REQ at the redirected fetch_pc.
REQ-025 jump SHALL take priority over stall and over any same-cycle inst_rvalid load.
REQ-026 fetch_pc SHALL wrap modulo 2^32, with no alignment check.

Reset
REQ-027 While reset=0, state SHALL be IDLE, fetch_pc=RESET_PC, inst_req=0, IDreg_valid=0, IDreg_pc=0, IDreg_inst=0, the drop flag SHALL be 0 and the skid register SHALL be empty.
REQ-028 Reset asserted mid-transaction SHALL abandon the request immediately, and any later inst_rvalid SHALL be ignored until the FSM reaches WAIT again.

Configuration
REQ-029 With YSYX_22050854_IFU_PERF_EN defined, the block SHALL add two outputs:
- perf_fetch_cnt (64 bits): counts IF/ID loads;
- perf_flush_cnt (64 bits): counts jump cycles.
Both SHALL reset to 0 and wrap.
REQ-030 Without YSYX_22050854_IFU_PERF_EN, neither port nor any counter logic SHALL exist, and function SHALL be otherwise identical.

Structure
REQ-031 The FSM state encoding, RESET_PC default and instruction width SHALL live in the shared ysyx_22050854_pkg package.
REQ-032 The skid register SHALL be a sub-module, ysyx_22050854_ifu_skid (1-entry buffer with pc, inst and valid fields plus a clear input); all other logic SHALL be flat.

Verification
REQ-033 Reset release, inst_ready tied to 1, rvalid one cycle after accept -> first request at 32'h8000_0000; IDreg_pc sequence 80000000, 80000004, 80000008.
REQ-034 stall=1 held for 5 cycles while rvalid returns 32'h00000013 -> FULL entered and inst_req=0; after stall drops, IDreg_inst=32'h00000013 next cycle, with no loss or duplication.
REQ-035 jump=1 with next_pc=32'h80000100 during WAIT -> the in-flight response is discarded, IDreg_valid=0, and the next inst_addr is 32'h80000100.
REQ-036 jump=1 in REQ with inst_ready=0 -> inst_addr stays stable until accepted, that response is dropped, and the following request goes to next_pc.
REQ-037 reset pulled low while in WAIT -> outputs go to reset values asynchronously, and the stale rvalid is ignored.
REQ-038 With YSYX_22050854_IFU_PERF_EN: 10 loads and 2 jumps -> perf_fetch_cnt=10 and perf_flush_cnt=2.
